// File: rtl/fir4_pkg.sv
// fir4_pkg
// Shared constants and width helpers for the 4-tap moving-sum FIR and its inverse.
//   W_DEFAULT  - default recovered sample width
//   CLA_GROUP  - bit width of one carry-lookahead group
//   sum_width  - width of a 4-tap sum of w-bit samples (two growth bits)
//   num_groups - number of CLA groups needed to cover a given adder width
package fir4_pkg;

    localparam int unsigned W_DEFAULT = 16;
    localparam int unsigned CLA_GROUP = 4;

    function automatic int unsigned sum_width(input int unsigned w);
        return w + 2;
    endfunction

    function automatic int unsigned num_groups(input int unsigned width);
        return (width + CLA_GROUP - 1) / CLA_GROUP;
    endfunction

endpackage

// File: rtl/fir4_cla.sv
// fir4_cla
// One carry-lookahead adder group (up to CLA_GROUP bits). Wider adders are
// built by chaining cout_o of one group into cin_i of the next.
// Ports:
//   a_i, b_i - addends
//   cin_i    - carry in
//   sum_o    - a_i + b_i + cin_i, low Width bits
//   cout_o   - carry out of the group
module fir4_cla
    import fir4_pkg::*;
#(
    parameter int unsigned Width = CLA_GROUP
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             cin_i,
    output logic [Width-1:0] sum_o,
    output logic             cout_o
);

    logic [Width-1:0] prop;
    logic [Width-1:0] gen;
    logic [Width:0]   carry;
    logic             acc;
    logic             run_p;

    assign prop = a_i ^ b_i;
    assign gen  = a_i & b_i;

    // Each carry is the flattened lookahead sum-of-products
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    // so no carry depends on a lower computed carry.
    always_comb begin
        carry    = '0;
        acc      = 1'b0;
        run_p    = 1'b0;
        carry[0] = cin_i;
        for (int i = 0; i < int'(Width); i++) begin
            acc   = gen[i];
            run_p = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (run_p & gen[j]);
                run_p = run_p & prop[j];
            end
            acc          = acc | (run_p & cin_i);
            carry[i + 1] = acc;
        end
    end

    assign sum_o  = prop ^ carry[Width-1:0];
    assign cout_o = carry[Width];

endmodule

// File: rtl/fir4_inverse.sv
// fir4_inverse
// Recovers the input stream x[n] of a 4-tap moving-sum FIR from its output
//   y[n] = x[n] + x[n-1] + x[n-2] + x[n-3]
// using x[n] = y[n] - y[n-1] + x[n-4], evaluated modulo 2^(w+2).
// Two pipeline stages: an input register, then the two chained CLA adds and the
// output register, so out_valid follows in_valid by exactly two cycles.
// Valid-only flow control, no backpressure; history advances only on valid samples.
// Ports:
//   clk       - clock, all state on posedge
//   reset     - synchronous active-high reset
//   in_valid  - in_sum carries a new 4-tap sum
//   in_sum    - unsigned 4-tap sum, w+2 bits
//   out_valid - out_a holds a newly recovered sample
//   out_a     - recovered sample, w bits
//   err       - sticky range-check flag
// Build option: define FIR4INV_CHECK_EN to flag (sticky, until reset) any valid
// result whose top two bits are nonzero; otherwise err is tied to 0.
module fir4_inverse
    import fir4_pkg::*;
#(
    parameter int unsigned w = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [w+1:0] in_sum,
    output logic         out_valid,
    output logic [w-1:0] out_a,
    output logic         err
);

    localparam int unsigned SW = sum_width(w);
    localparam int unsigned NG = num_groups(SW);

    // Input stage
    logic          in_valid_q, in_valid_d;
    logic [SW-1:0] in_sum_q, in_sum_d;

    // History
    logic [SW-1:0] y_prev_q, y_prev_d;
    logic [w-1:0]  x1_q, x1_d;
    logic [w-1:0]  x2_q, x2_d;
    logic [w-1:0]  x3_q, x3_d;
    logic [w-1:0]  x4_q, x4_d;

    // Output stage
    logic          out_valid_q, out_valid_d;
    logic [w-1:0]  out_a_q, out_a_d;

    // Datapath
    logic [SW-1:0] y_prev_n;
    logic [SW-1:0] x4_ext;
    logic [SW-1:0] diff;
    logic [SW-1:0] res;
    logic [NG:0]   c_sub;
    logic [NG:0]   c_add;

    // y - y_prev as y + ~y_prev + 1: the +1 is the carry-in of the first group.
    assign y_prev_n = ~y_prev_q;
    assign x4_ext   = {{(SW - w){1'b0}}, x4_q};
    assign c_sub[0] = 1'b1;
    assign c_add[0] = 1'b0;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int unsigned Lo = gi * CLA_GROUP;
        // The top group is partial when SW is not a multiple of CLA_GROUP.
        localparam int unsigned Gw = (SW - Lo < CLA_GROUP) ? (SW - Lo) : CLA_GROUP;

        fir4_cla #(
            .Width (Gw)
        ) u_sub (
            .a_i    (in_sum_q[Lo +: Gw]),
            .b_i    (y_prev_n[Lo +: Gw]),
            .cin_i  (c_sub[gi]),
            .sum_o  (diff[Lo +: Gw]),
            .cout_o (c_sub[gi + 1])
        );

        fir4_cla #(
            .Width (Gw)
        ) u_add (
            .a_i    (diff[Lo +: Gw]),
            .b_i    (x4_ext[Lo +: Gw]),
            .cin_i  (c_add[gi]),
            .sum_o  (res[Lo +: Gw]),
            .cout_o (c_add[gi + 1])
        );
    end

    always_comb begin
        in_valid_d  = in_valid;
        // Hold the captured sum across gaps to avoid needless toggling.
        in_sum_d    = in_valid ? in_sum : in_sum_q;

        y_prev_d    = y_prev_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;
        x4_d        = x4_q;
        out_valid_d = in_valid_q;
        out_a_d     = out_a_q;

        if (in_valid_q) begin
            y_prev_d = in_sum_q;
            x1_d     = res[w-1:0];
            x2_d     = x1_q;
            x3_d     = x2_q;
            x4_d     = x3_q;
            out_a_d  = res[w-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_q  <= 1'b0;
            in_sum_q    <= '0;
            y_prev_q    <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            x4_q        <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
        end else begin
            in_valid_q  <= in_valid_d;
            in_sum_q    <= in_sum_d;
            y_prev_q    <= y_prev_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            x4_q        <= x4_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;

`ifdef FIR4INV_CHECK_EN
    logic err_q, err_d;

    // A consistent sum stream never produces a result of w+1 bits or more.
    always_comb begin
        err_d = err_q;
        if (in_valid_q && (res[SW-1:w] != '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    // Modular arithmetic: the final group carries are intentionally dropped.
    logic unused_carries;
    assign unused_carries = ^{c_sub[NG], c_add[NG]};
`else
    assign err = 1'b0;

    logic unused_carries;
    assign unused_carries = ^{c_sub[NG], c_add[NG], res[SW-1:w]};
`endif

endmodule

// File: tb/tb_fir4_inverse.sv
module tb_fir4_inverse;

    localparam int unsigned W = 16;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         in_valid = 1'b0;
    logic [W+1:0] in_sum   = '0;
    logic         out_valid;
    logic [W-1:0] out_a;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] vec_y [5];
    logic [W-1:0] vec_x [5];
    logic [W-1:0] stream_x [200];

    fir4_inverse #(
        .w (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_a     (out_a),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sum   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_basic();
        vec_y = '{18'd5, 18'd12, 18'd18, 18'd26, 18'd30};
        vec_x = '{16'd5, 16'd7, 16'd6, 16'd8, 16'd9};
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_a !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_a=%h err=%b, expected 0 0000 0",
                     out_valid, out_a, err);
        end
        // Reset and in_valid together: the sample must be dropped.
        in_valid = 1'b1;
        in_sum   = 18'd7;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sum   = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_priority[%0d]: out_valid=%b, expected 0", k, out_valid);
            end
        end
        // History must still be clear: 5 - 0 + 0 = 5.
        in_valid = 1'b1;
        in_sum   = 18'd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 16'd5) begin
            errors++;
            $display("FAIL reset_history: out_valid=%b out_a=%h, expected 1 0005",
                     out_valid, out_a);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        load_basic();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (k >= 2) begin
                if (out_valid !== 1'b1 || out_a !== vec_x[k-2]) begin
                    errors++;
                    $display("FAIL basic[%0d]: out_valid=%b out_a=%h, expected 1 %h",
                             k - 2, out_valid, out_a, vec_x[k-2]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_latency[%0d]: out_valid=%b, expected 0", k, out_valid);
            end
            in_valid = (k < 5);
            in_sum   = (k < 5) ? vec_y[k] : '0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_a !== 16'd9) begin
            errors++;
            $display("FAIL basic_drain: out_valid=%b out_a=%h, expected 0 0009",
                     out_valid, out_a);
        end
    endtask

    task automatic test_max();
        apply_reset();
        vec_y = '{18'h0FFFF, 18'h1FFFE, 18'h2FFFD, 18'h3FFFC, 18'h3FFFC};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_a !== 16'hFFFF || err !== 1'b0) begin
                    errors++;
                    $display("FAIL max[%0d]: out_valid=%b out_a=%h err=%b, expected 1 ffff 0",
                             k - 2, out_valid, out_a, err);
                end
            end
            in_valid = (k < 5);
            in_sum   = (k < 5) ? vec_y[k] : '0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gaps();
        logic [W-1:0] last;
        apply_reset();
        load_basic();
        last = '0;
        for (int t = 0; t < 22; t++) begin
            @(negedge clk);
            checks++;
            if (t >= 2 && ((t - 2) % 4) == 0 && ((t - 2) / 4) < 5) begin
                if (out_valid !== 1'b1 || out_a !== vec_x[(t-2)/4]) begin
                    errors++;
                    $display("FAIL gaps_out[%0d]: out_valid=%b out_a=%h, expected 1 %h",
                             (t - 2) / 4, out_valid, out_a, vec_x[(t-2)/4]);
                end
                last = vec_x[(t-2)/4];
            end else if (out_valid !== 1'b0 || out_a !== last) begin
                errors++;
                $display("FAIL gaps_idle[t=%0d]: out_valid=%b out_a=%h, expected 0 %h",
                         t, out_valid, out_a, last);
            end
            in_valid = ((t % 4) == 0) && (t / 4 < 5);
            in_sum   = in_valid ? vec_y[t/4] : '0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        load_basic();
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            if (t == 2 || t == 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_a !== vec_x[t-2]) begin
                    errors++;
                    $display("FAIL midreset_pre[%0d]: out_valid=%b out_a=%h, expected 1 %h",
                             t - 2, out_valid, out_a, vec_x[t-2]);
                end
            end else if (t == 4 || t == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_flush[t=%0d]: out_valid=%b, expected 0",
                             t, out_valid);
                end
            end else if (t == 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_a !== 16'd4) begin
                    errors++;
                    $display("FAIL midreset_post: out_valid=%b out_a=%h, expected 1 0004",
                             out_valid, out_a);
                end
            end
            reset    = (t == 3);
            in_valid = (t < 3) || (t == 4);
            in_sum   = (t < 3) ? vec_y[t] : ((t == 4) ? 18'd4 : 18'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef FIR4INV_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        apply_reset();
        in_valid = 1'b1;
        in_sum   = 18'h10000;
        @(negedge clk);
        in_sum   = 18'h10003;
        @(negedge clk);
        in_valid = 1'b0;
        in_sum   = '0;
        checks++;
        if (out_valid !== 1'b1 || out_a !== 16'h0000 || err !== exp_err) begin
            errors++;
            $display("FAIL err_set: out_valid=%b out_a=%h err=%b, expected 1 0000 %b",
                     out_valid, out_a, err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 16'h0003 || err !== exp_err) begin
            errors++;
            $display("FAIL err_hold_valid: out_valid=%b out_a=%h err=%b, expected 1 0003 %b",
                     out_valid, out_a, err, exp_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_sticky: err=%b, expected %b", err, exp_err);
        end
        apply_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, expected 0", err);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] h1, h2, h3, x;
        apply_reset();
        h1 = '0;
        h2 = '0;
        h3 = '0;
        for (int t = 0; t < 202; t++) begin
            @(negedge clk);
            checks++;
            if (t >= 2) begin
                if (out_valid !== 1'b1 || out_a !== stream_x[t-2] || err !== 1'b0) begin
                    errors++;
                    $display("FAIL stream[%0d]: out_valid=%b out_a=%h err=%b, expected 1 %h 0",
                             t - 2, out_valid, out_a, err, stream_x[t-2]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_latency[%0d]: out_valid=%b, expected 0", t, out_valid);
            end
            if (t < 200) begin
                x           = W'($urandom);
                stream_x[t] = x;
                in_valid    = 1'b1;
                in_sum      = {2'b00, x} + {2'b00, h1} + {2'b00, h2} + {2'b00, h3};
                h3          = h2;
                h2          = h1;
                h1          = x;
            end else begin
                in_valid = 1'b0;
                in_sum   = '0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_gaps();
        test_mid_reset();
        test_err();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
